// File: rtl/imm_pkg.sv
// Shared format codes, opcode constants and the immediate extend function
// for the decode-stage immediate generator.
package imm_pkg;

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
  localparam logic [2:0] FMT_SH   = 3'b101;
  localparam logic [2:0] FMT_Z    = 3'b110;
  localparam logic [2:0] FMT_NONE = 3'b111;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Returns the low 32 bits; every format's upper bits (XLEN=64) equal bit 31
  // of this result, so the caller widens by replicating bit 31.
  function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                             input logic [2:0]  fmt,
                                             input int unsigned xlen);
    logic [31:0] res;
    res = 32'd0;
    case (fmt)
      FMT_I:   res = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   res = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   res = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J:   res = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:   res = {instr[31:12], 12'd0};
      FMT_SH:  res = (xlen == 32'd64) ? {26'd0, instr[25:20]} : {27'd0, instr[24:20]};
      FMT_Z:   res = {27'd0, instr[19:15]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready instruction-in, immediate-out bundle for imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic [2:0]           imm_src;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      imm_out;
  logic [2:0]           fmt_out;
  logic                 illegal_out;
  logic [ILL_CNT_W-1:0] ill_count;

  modport master (
    output in_valid, instr, imm_src, out_ready,
    input  in_ready, out_valid, imm_out, fmt_out, illegal_out, ill_count
  );

  modport slave (
    input  in_valid, instr, imm_src, out_ready,
    output in_ready, out_valid, imm_out, fmt_out, illegal_out, ill_count
  );
endinterface

// File: rtl/imm_fmt_decode.sv
// Combinational opcode/funct3 to immediate-format decode with illegal flag.
module imm_fmt_decode
  import imm_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_fmt,
  output logic       o_illegal
);

  // Opcode-driven format selection; unknown opcodes yield NONE and illegal.
  always_comb begin
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_LOAD, OPC_JALR, OPC_FENCE: o_fmt = FMT_I;
      OPC_OPIMM: begin
        if ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) begin
          o_fmt = FMT_SH;
        end else begin
          o_fmt = FMT_I;
        end
      end
      OPC_STORE:          o_fmt = FMT_S;
      OPC_BRANCH:         o_fmt = FMT_B;
      OPC_JAL:            o_fmt = FMT_J;
      OPC_LUI, OPC_AUIPC: o_fmt = FMT_U;
      OPC_SYSTEM: begin
        if (i_funct3[2]) begin
          o_fmt = FMT_Z;
        end else begin
          o_fmt = FMT_I;
        end
      end
      OPC_OP:  o_fmt = FMT_NONE;
      default: begin
        o_fmt     = FMT_NONE;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a valid/ready handshake with a
// main/skid entry pair; outputs come straight from the main entry.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1,
  parameter int ILL_CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  logic [2:0]           w_fmt_dec;
  logic                 w_ill_dec;
  logic [2:0]           w_fmt;
  logic                 w_ill;
  logic [31:0]          w_imm32;
  logic [XLEN-1:0]      w_imm;
  logic                 w_accept;
  logic                 w_main_free;

  logic                 r_main_valid;
  logic [XLEN-1:0]      r_main_imm;
  logic [2:0]           r_main_fmt;
  logic                 r_main_ill;
  logic                 r_skid_valid;
  logic [XLEN-1:0]      r_skid_imm;
  logic [2:0]           r_skid_fmt;
  logic                 r_skid_ill;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  imm_fmt_decode u_dec (
    .i_opcode  (bus.instr[6:0]),
    .i_funct3  (bus.instr[14:12]),
    .o_fmt     (w_fmt_dec),
    .o_illegal (w_ill_dec)
  );

  // Format source: opcode decode or the control unit's imm_src.
  always_comb begin
    w_fmt = FMT_NONE;
    w_ill = 1'b0;
    if (AUTO_DECODE != 0) begin
      w_fmt = w_fmt_dec;
      w_ill = w_ill_dec;
    end else begin
      w_fmt = bus.imm_src;
      w_ill = 1'b0;
    end
  end

  assign w_imm32 = imm_extend(bus.instr, w_fmt, XLEN);

  if (XLEN > 32) begin : g_wide
    assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  end else begin : g_narrow
    assign w_imm = w_imm32;
  end

  assign w_accept    = bus.in_valid & ~r_skid_valid & ~flush;
  assign w_main_free = ~r_main_valid | bus.out_ready;

  // Main/skid entry update; skid has priority for refilling main to keep order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_fmt   <= FMT_NONE;
      r_main_ill   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_fmt   <= FMT_NONE;
      r_skid_ill   <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= r_skid_imm;
        r_main_fmt   <= r_skid_fmt;
        r_main_ill   <= r_skid_ill;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= w_imm;
        r_main_fmt   <= w_fmt;
        r_main_ill   <= w_ill;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_fmt   <= w_fmt;
      r_skid_ill   <= w_ill;
    end
  end

  // Saturating count of accepted illegal instructions; survives flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ill_cnt <= '0;
    end else if (w_accept && w_ill && !(&r_ill_cnt)) begin
      r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
    end
  end

  assign bus.in_ready    = ~r_skid_valid;
  assign bus.out_valid   = r_main_valid;
  assign bus.imm_out     = r_main_imm;
  assign bus.fmt_out     = r_main_fmt;
  assign bus.illegal_out = r_main_ill;
  assign bus.ill_count   = r_ill_cnt;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It generalises the combinational sign-extender in four ways:
- XLEN is configurable.
- It covers all RV immediate formats, including U-type, shift-amount and CSR-zimm.
- It can decode the format from the opcode itself, or take the format from the control unit.
- It sits behind a valid/ready handshake with a 2-entry skid buffer, so it can be placed on the fetch→decode boundary under stall/backpressure.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- AUTO_DECODE, 1, 1 = derive the format from the opcode/funct3; 0 = use the imm_src input.
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction valid.
- in_ready  out  1  block can accept an instruction.
- instr  in  32  full instruction word.
- imm_src  in  3  format code; used only when AUTO_DECODE=0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- imm_out  out  XLEN  extended immediate.
- fmt_out  out  3  format code applied to this instruction.
- illegal_out  out  1  opcode not recognised (AUTO_DECODE=1 only).
- ill_count  out  ILL_CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Format codes:
  - 000 I: sign-extend instr[31:20].
  - 001 S: sign-extend {instr[31:25], instr[11:7]}.
  - 010 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 101 SH: zero-extend instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 110 Z: zero-extend instr[19:15].
  - 111 NONE: imm = 0.
- Auto-decode on instr[6:0]:
  - 0000011 load, 1100111 JALR, 0001111 FENCE → I.
  - 0010011 OP-IMM → SH when funct3 ∈ {001, 101}, else I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 1110011 SYSTEM → Z when funct3[2]=1, else I.
  - 0110011 R-type → NONE.
  - Any other opcode → NONE with illegal=1.
  - When AUTO_DECODE=0, illegal is always 0.
- Datapath: the extend result is computed combinationally at the input and captured into the entry. The output is fully registered, with no combinational input→output path.
- Storage: main entry (drives the outputs) plus a skid entry.
  - in_ready = ~skid_valid (registered signal).
  - Accept when in_valid & in_ready & ~flush.
  - Accept and main empty, or main draining this cycle (out_ready) → load main.
  - Accept while main is held (out_valid & ~out_ready) → load skid.
  - When main drains and skid is valid → skid moves to main, skid clears.
- Latency: 1 cycle from accept to out_valid. Full throughput is 1 instruction per cycle when out_ready=1.
- Order is preserved. While out_valid=1 and out_ready=0, outputs are held stable.
- Flush:
  - Clears main_valid and skid_valid on the next edge.
  - Has priority over a same-cycle accept: the input is dropped and not counted.
  - Data registers are not cleared.
- ill_count:
  - +1 on each accepted instruction with illegal=1.
  - Saturates at all-ones.
  - Not cleared by flush.
- Reset (asynchronous):
  - out_valid=0, skid_valid=0, so in_ready=1.
  - imm_out=0, fmt_out=3'b111, illegal_out=0, ill_count=0.
  - Reset mid-transfer discards both entries.
- XLEN=64: U and sign-extended formats replicate instr[31] across the upper 32 bits.

Decomposition:
- Package imm_pkg holds:
  - the format-code localparams (FMT_I … FMT_NONE);
  - the opcode constants;
  - a function imm_extend(instr, fmt) parametrised by XLEN.
- One natural sub-module: imm_fmt_decode (combinational opcode/funct3 → fmt, illegal).
- The skid buffer stays inline.

Test Plan:
1. XLEN=32, AUTO, out_ready=1. Stream 0xFFF00093, 0xFE000EE3, 0x123452B7 → results on consecutive cycles, each 1 cycle after accept:
   - imm 0xFFFFFFFF fmt 000;
   - imm 0xFFFFFFFC fmt 010;
   - imm 0x12345000 fmt 100.
2. Shift and CSR formats:
   - 0x01F09093 → imm 0x1F fmt 101.
   - 0x4030D093 → imm 0x3 fmt 101 (funct7 bit ignored).
   - 0x3002D073 → imm 0x5 fmt 110.
   - 0x00208033 → imm 0 fmt 111 illegal 0.
3. Backpressure: hold out_ready=0 and offer 3 instructions.
   - 1st → main, 2nd → skid, in_ready falls; 3rd is held off.
   - Release out_ready → outputs in order 1, 2, 3; no loss or duplicate; outputs stable while stalled.
4. Illegal/counter: ILL_CNT_W=2, send 5× 0x0000007F → illegal_out=1 each, ill_count saturates at 3. Flush concurrent with a 6th illegal → count stays 3, out_valid drops next cycle.
5. XLEN=64, AUTO_DECODE=0:
   - imm_src=100 with instr 0x800002B7 → imm 0xFFFFFFFF80000000.
   - imm_src=101 with 0x03F09093 → imm 0x3F.
6. Assert reset asynchronously with both entries full → out_valid=0, in_ready=1, imm_out=0, fmt_out=111, ill_count=0 immediately, without waiting for a clock edge.
